// File: rtl/apb2axi_rsp_slicer.sv
// apb2axi_rsp_slicer
//   Per-tag read-data buffer and APB word slicer for the APB2AXI bridge response path.
//   AXI R beats are stored in per-tag circular queues; APB-side requests drain one
//   APB word per request, lowest word of each beat first.
//
// Ports
//   pclk, preset         clock, synchronous active-high reset
//   in_vld/in_rdy        R beat handshake; in_tag, in_data, in_resp, in_last carry the beat
//   req_vld/req_rdy      APB word request handshake for tag req_tag
//   out_vld/out_rdy      registered word output: out_data, out_resp, out_last, out_empty
//   flush_vld/flush_tag  discard all queued state for one tag
//   tag_count            queued (not yet started) beats per tag, tag 0 in the LSBs
//   ovf_err, unf_err     sticky per-tag overflow / underflow flags
module apb2axi_rsp_slicer #(
  parameter int unsigned TAG_NUM       = 4,
  parameter int unsigned APB_DATA_W    = 32,
  parameter int unsigned AXI_DATA_W    = 64,
  parameter int unsigned BEATS_PER_TAG = 8,
  parameter int unsigned RESP_W        = 2,
  localparam int unsigned TAG_W = (TAG_NUM > 1) ? $clog2(TAG_NUM) : 1,
  localparam int unsigned CNT_W = $clog2(BEATS_PER_TAG + 1)
) (
  input  logic                     pclk,
  input  logic                     preset,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic [AXI_DATA_W-1:0]    in_data,
  input  logic [RESP_W-1:0]        in_resp,
  input  logic                     in_last,
  input  logic                     req_vld,
  output logic                     req_rdy,
  input  logic [TAG_W-1:0]         req_tag,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [APB_DATA_W-1:0]    out_data,
  output logic [RESP_W-1:0]        out_resp,
  output logic                     out_last,
  output logic                     out_empty,
  input  logic                     flush_vld,
  input  logic [TAG_W-1:0]         flush_tag,
  output logic [TAG_NUM*CNT_W-1:0] tag_count,
  output logic [TAG_NUM-1:0]       ovf_err,
  output logic [TAG_NUM-1:0]       unf_err
);

  localparam int unsigned RATIO = AXI_DATA_W / APB_DATA_W;
  localparam int unsigned PTR_W = $clog2(BEATS_PER_TAG);
  localparam int unsigned IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BEATS_PER_TAG);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  // Beat storage (not reset)
  logic [AXI_DATA_W-1:0] r_mem_data [TAG_NUM][BEATS_PER_TAG];
  logic [RESP_W-1:0]     r_mem_resp [TAG_NUM][BEATS_PER_TAG];
  logic                  r_mem_last [TAG_NUM][BEATS_PER_TAG];

  // Queue pointers and counts
  logic [PTR_W-1:0] r_head  [TAG_NUM];
  logic [PTR_W-1:0] r_tail  [TAG_NUM];
  logic [CNT_W-1:0] r_count [TAG_NUM];

  // Slice state: the beat currently being emitted word by word
  logic [TAG_NUM-1:0]    r_cur_valid;
  logic [IDX_W-1:0]      r_cur_idx  [TAG_NUM];
  logic [AXI_DATA_W-1:0] r_cur_data [TAG_NUM];
  logic [RESP_W-1:0]     r_cur_resp [TAG_NUM];
  logic                  r_cur_last [TAG_NUM];

  // Output and status registers
  logic                  r_out_vld;
  logic [APB_DATA_W-1:0] r_out_data;
  logic [RESP_W-1:0]     r_out_resp;
  logic                  r_out_last;
  logic                  r_out_empty;
  logic [TAG_NUM-1:0]    r_ovf;
  logic [TAG_NUM-1:0]    r_unf;

  // Write-side decode
  logic [CNT_W-1:0] w_in_cnt;
  logic             w_in_full;
  logic             w_in_flush;
  logic             w_push;
  logic             w_ovf;

  // Request-side decode, state of req_tag
  logic                  w_req_flush;
  logic                  w_req_fire;
  logic [CNT_W-1:0]      w_sel_cnt;
  logic                  w_sel_cur_valid;
  logic [IDX_W-1:0]      w_sel_cur_idx;
  logic [AXI_DATA_W-1:0] w_sel_cur_data;
  logic [RESP_W-1:0]     w_sel_cur_resp;
  logic                  w_sel_cur_last;
  logic [APB_DATA_W-1:0] w_sel_head_word;
  logic [RESP_W-1:0]     w_sel_head_resp;
  logic                  w_sel_head_last;
  logic                  w_pop;
  logic                  w_empty_rsp;
  logic                  w_adv;

  // Word about to be registered
  logic [APB_DATA_W-1:0] w_word;
  logic [RESP_W-1:0]     w_word_resp;
  logic                  w_word_last;
  logic                  w_word_empty;

  // Per-tag one-hot events
  logic [TAG_NUM-1:0] w_push_vec;
  logic [TAG_NUM-1:0] w_pop_vec;
  logic [TAG_NUM-1:0] w_adv_vec;
  logic [TAG_NUM-1:0] w_flush_vec;
  logic [TAG_NUM-1:0] w_ovf_vec;
  logic [TAG_NUM-1:0] w_unf_vec;

  // ---------------------------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    w_in_cnt = '0;
    for (int t = 0; t < TAG_NUM; t++) begin
      if (in_tag == TAG_W'(t)) w_in_cnt = r_count[t];
    end
  end

  assign w_in_full  = (w_in_cnt == FULL_CNT);
  assign w_in_flush = flush_vld && (flush_tag == in_tag);
  assign in_rdy     = !w_in_full && !w_in_flush;
  assign w_push     = in_vld && in_rdy;
  // A flushed tag clears its status anyway, so only a genuine full drop flags overflow
  assign w_ovf      = in_vld && w_in_full && !w_in_flush;

  // ---------------------------------------------------------------------------------------------
  // Request side
  // ---------------------------------------------------------------------------------------------
  assign w_req_flush = flush_vld && (flush_tag == req_tag);
  assign req_rdy     = (!r_out_vld || out_rdy) && !w_req_flush;
  assign w_req_fire  = req_vld && req_rdy;

  always_comb begin
    w_sel_cnt       = '0;
    w_sel_cur_valid = 1'b0;
    w_sel_cur_idx   = '0;
    w_sel_cur_data  = '0;
    w_sel_cur_resp  = '0;
    w_sel_cur_last  = 1'b0;
    w_sel_head_word = '0;
    w_sel_head_resp = '0;
    w_sel_head_last = 1'b0;
    for (int t = 0; t < TAG_NUM; t++) begin
      if (req_tag == TAG_W'(t)) begin
        w_sel_cnt       = r_count[t];
        w_sel_cur_valid = r_cur_valid[t];
        w_sel_cur_idx   = r_cur_idx[t];
        w_sel_cur_data  = r_cur_data[t];
        w_sel_cur_resp  = r_cur_resp[t];
        w_sel_cur_last  = r_cur_last[t];
        w_sel_head_word = r_mem_data[t][r_head[t]][APB_DATA_W-1:0];
        w_sel_head_resp = r_mem_resp[t][r_head[t]];
        w_sel_head_last = r_mem_last[t][r_head[t]];
      end
    end
  end

  // Counts are pre-push, so a pop never sees a beat written in the same cycle
  assign w_pop       = w_req_fire && !w_sel_cur_valid && (w_sel_cnt != '0);
  assign w_empty_rsp = w_req_fire && !w_sel_cur_valid && (w_sel_cnt == '0);
  assign w_adv       = w_req_fire && w_sel_cur_valid;

  always_comb begin
    w_word       = '0;
    w_word_resp  = '0;
    w_word_last  = 1'b1;
    w_word_empty = 1'b1;
    if (w_sel_cur_valid) begin
      for (int i = 0; i < RATIO; i++) begin
        if (w_sel_cur_idx == IDX_W'(i)) w_word = w_sel_cur_data[i*APB_DATA_W +: APB_DATA_W];
      end
      w_word_resp  = w_sel_cur_resp;
      w_word_last  = w_sel_cur_last && (w_sel_cur_idx == LAST_IDX);
      w_word_empty = 1'b0;
    end else if (w_sel_cnt != '0) begin
      w_word       = w_sel_head_word;
      w_word_resp  = w_sel_head_resp;
      // Word 0 is only the final word when a beat is a single APB word
      w_word_last  = w_sel_head_last && (RATIO == 1);
      w_word_empty = 1'b0;
    end
  end

  always_comb begin
    w_push_vec  = '0;
    w_pop_vec   = '0;
    w_adv_vec   = '0;
    w_flush_vec = '0;
    w_ovf_vec   = '0;
    w_unf_vec   = '0;
    for (int t = 0; t < TAG_NUM; t++) begin
      w_push_vec[t]  = w_push && (in_tag == TAG_W'(t));
      w_ovf_vec[t]   = w_ovf && (in_tag == TAG_W'(t));
      w_pop_vec[t]   = w_pop && (req_tag == TAG_W'(t));
      w_adv_vec[t]   = w_adv && (req_tag == TAG_W'(t));
      w_unf_vec[t]   = w_empty_rsp && (req_tag == TAG_W'(t));
      w_flush_vec[t] = flush_vld && (flush_tag == TAG_W'(t));
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Storage and latched beat data (not reset)
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge pclk) begin
    for (int t = 0; t < TAG_NUM; t++) begin
      if (w_push_vec[t]) begin
        r_mem_data[t][r_tail[t]] <= in_data;
        r_mem_resp[t][r_tail[t]] <= in_resp;
        r_mem_last[t][r_tail[t]] <= in_last;
      end
      if (w_pop_vec[t]) begin
        r_cur_data[t] <= r_mem_data[t][r_head[t]];
        r_cur_resp[t] <= r_mem_resp[t][r_head[t]];
        r_cur_last[t] <= r_mem_last[t][r_head[t]];
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Queue control, slice state, status
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int t = 0; t < TAG_NUM; t++) begin
        r_head[t]    <= '0;
        r_tail[t]    <= '0;
        r_count[t]   <= '0;
        r_cur_idx[t] <= '0;
      end
      r_cur_valid <= '0;
      r_ovf       <= '0;
      r_unf       <= '0;
    end else begin
      for (int t = 0; t < TAG_NUM; t++) begin
        if (w_flush_vec[t]) begin
          r_head[t]      <= '0;
          r_tail[t]      <= '0;
          r_count[t]     <= '0;
          r_cur_valid[t] <= 1'b0;
          r_cur_idx[t]   <= '0;
          r_ovf[t]       <= 1'b0;
          r_unf[t]       <= 1'b0;
        end else begin
          if (w_push_vec[t]) r_tail[t] <= r_tail[t] + 1'b1;
          if (w_pop_vec[t])  r_head[t] <= r_head[t] + 1'b1;
          if (w_push_vec[t] && !w_pop_vec[t]) begin
            r_count[t] <= r_count[t] + CNT_W'(1);
          end else if (!w_push_vec[t] && w_pop_vec[t]) begin
            r_count[t] <= r_count[t] - CNT_W'(1);
          end

          if (w_pop_vec[t] && (RATIO > 1)) begin
            r_cur_valid[t] <= 1'b1;
            r_cur_idx[t]   <= IDX_W'(1);
          end else if (w_adv_vec[t]) begin
            if (r_cur_idx[t] == LAST_IDX) begin
              r_cur_valid[t] <= 1'b0;
              r_cur_idx[t]   <= '0;
            end else begin
              r_cur_idx[t] <= r_cur_idx[t] + IDX_W'(1);
            end
          end

          if (w_ovf_vec[t]) r_ovf[t] <= 1'b1;
          if (w_unf_vec[t]) r_unf[t] <= 1'b1;
        end
      end
    end
  end

  // Output register: a registered word survives a flush of its tag
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_out_vld   <= 1'b0;
      r_out_data  <= '0;
      r_out_resp  <= '0;
      r_out_last  <= 1'b0;
      r_out_empty <= 1'b0;
    end else if (w_req_fire) begin
      r_out_vld   <= 1'b1;
      r_out_data  <= w_word;
      r_out_resp  <= w_word_resp;
      r_out_last  <= w_word_last;
      r_out_empty <= w_word_empty;
    end else if (out_rdy) begin
      r_out_vld <= 1'b0;
    end
  end

  always_comb begin
    tag_count = '0;
    for (int t = 0; t < TAG_NUM; t++) begin
      tag_count[t*CNT_W +: CNT_W] = r_count[t];
    end
  end

  assign out_vld   = r_out_vld;
  assign out_data  = r_out_data;
  assign out_resp  = r_out_resp;
  assign out_last  = r_out_last;
  assign out_empty = r_out_empty;
  assign ovf_err   = r_ovf;
  assign unf_err   = r_unf;

endmodule

// File: tb/tb_apb2axi_rsp_slicer.sv
// Self-checking bench for apb2axi_rsp_slicer (default parameters).
// Reference model: each tag is a plain queue of APB words; a pushed beat appends RATIO
// words, a request pops one word, and the beat count is the number of whole beats left.
module tb_apb2axi_rsp_slicer;

  localparam int TAG_NUM = 4;
  localparam int APB     = 32;
  localparam int AXI     = 64;
  localparam int DEPTH   = 8;
  localparam int RESP_W  = 2;
  localparam int RATIO   = AXI / APB;
  localparam int TAG_W   = 2;
  localparam int CNT_W   = 4;

  logic                     pclk = 1'b0;
  logic                     preset;
  logic                     in_vld;
  logic                     in_rdy;
  logic [TAG_W-1:0]         in_tag;
  logic [AXI-1:0]           in_data;
  logic [RESP_W-1:0]        in_resp;
  logic                     in_last;
  logic                     req_vld;
  logic                     req_rdy;
  logic [TAG_W-1:0]         req_tag;
  logic                     out_vld;
  logic                     out_rdy;
  logic [APB-1:0]           out_data;
  logic [RESP_W-1:0]        out_resp;
  logic                     out_last;
  logic                     out_empty;
  logic                     flush_vld;
  logic [TAG_W-1:0]         flush_tag;
  logic [TAG_NUM*CNT_W-1:0] tag_count;
  logic [TAG_NUM-1:0]       ovf_err;
  logic [TAG_NUM-1:0]       unf_err;

  always #5 pclk = ~pclk;

  apb2axi_rsp_slicer dut (
    .pclk      (pclk),
    .preset    (preset),
    .in_vld    (in_vld),
    .in_rdy    (in_rdy),
    .in_tag    (in_tag),
    .in_data   (in_data),
    .in_resp   (in_resp),
    .in_last   (in_last),
    .req_vld   (req_vld),
    .req_rdy   (req_rdy),
    .req_tag   (req_tag),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .out_data  (out_data),
    .out_resp  (out_resp),
    .out_last  (out_last),
    .out_empty (out_empty),
    .flush_vld (flush_vld),
    .flush_tag (flush_tag),
    .tag_count (tag_count),
    .ovf_err   (ovf_err),
    .unf_err   (unf_err)
  );

  typedef struct packed {
    logic [APB-1:0]    d;
    logic [RESP_W-1:0] r;
    logic              l;
  } word_t;

  word_t wq [TAG_NUM][$];

  logic               m_out_vld;
  logic [APB-1:0]     m_out_data;
  logic [RESP_W-1:0]  m_out_resp;
  logic               m_out_last;
  logic               m_out_empty;
  logic [TAG_NUM-1:0] m_ovf;
  logic [TAG_NUM-1:0] m_unf;

  int n_cmp;
  int n_fail;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < TAG_NUM; t++) wq[t].delete();
    m_out_vld   = 1'b0;
    m_out_data  = '0;
    m_out_resp  = '0;
    m_out_last  = 1'b0;
    m_out_empty = 1'b0;
    m_ovf       = '0;
    m_unf       = '0;
  endtask

  task automatic check_outs();
    chk("out_vld", 64'(out_vld), 64'(m_out_vld));
    chk("out_data", 64'(out_data), 64'(m_out_data));
    chk("out_resp", 64'(out_resp), 64'(m_out_resp));
    chk("out_last", 64'(out_last), 64'(m_out_last));
    chk("out_empty", 64'(out_empty), 64'(m_out_empty));
    for (int t = 0; t < TAG_NUM; t++) begin
      chk($sformatf("tag_count[%0d]", t), 64'(tag_count[t*CNT_W +: CNT_W]),
          64'(wq[t].size() / RATIO));
    end
    chk("ovf_err", 64'(ovf_err), 64'(m_ovf));
    chk("unf_err", 64'(unf_err), 64'(m_unf));
  endtask

  // One clock: check combinational readies, advance the model with the driven inputs,
  // then check all registered outputs just after the edge.
  task automatic tick();
    logic  full, same_flush, exp_in_rdy, exp_req_rdy;
    word_t w;
    #1;
    full        = (wq[in_tag].size() / RATIO) >= DEPTH;
    same_flush  = flush_vld && (flush_tag == in_tag);
    exp_in_rdy  = !full && !same_flush;
    exp_req_rdy = (!m_out_vld || out_rdy) && !(flush_vld && (flush_tag == req_tag));
    chk("in_rdy", 64'(in_rdy), 64'(exp_in_rdy));
    chk("req_rdy", 64'(req_rdy), 64'(exp_req_rdy));
    @(posedge pclk);
    if (preset) begin
      model_reset();
    end else begin
      if (req_vld && exp_req_rdy) begin
        if (wq[req_tag].size() == 0) begin
          m_out_data  = '0;
          m_out_resp  = '0;
          m_out_last  = 1'b1;
          m_out_empty = 1'b1;
          m_unf[req_tag] = 1'b1;
        end else begin
          w = wq[req_tag].pop_front();
          m_out_data  = w.d;
          m_out_resp  = w.r;
          m_out_last  = w.l;
          m_out_empty = 1'b0;
        end
        m_out_vld = 1'b1;
      end else if (out_rdy) begin
        m_out_vld = 1'b0;
      end
      if (in_vld && exp_in_rdy) begin
        for (int i = 0; i < RATIO; i++) begin
          w.d = in_data[i*APB +: APB];
          w.r = in_resp;
          w.l = in_last && (i == RATIO - 1);
          wq[in_tag].push_back(w);
        end
      end else if (in_vld && full && !same_flush) begin
        m_ovf[in_tag] = 1'b1;
      end
      if (flush_vld) begin
        wq[flush_tag].delete();
        m_ovf[flush_tag] = 1'b0;
        m_unf[flush_tag] = 1'b0;
      end
    end
    #1;
    check_outs();
  endtask

  task automatic idle();
    preset    = 1'b0;
    in_vld    = 1'b0;
    in_tag    = '0;
    in_data   = '0;
    in_resp   = '0;
    in_last   = 1'b0;
    req_vld   = 1'b0;
    req_tag   = '0;
    out_rdy   = 1'b1;
    flush_vld = 1'b0;
    flush_tag = '0;
  endtask

  task automatic push(input int tag, input logic [AXI-1:0] data, input logic last);
    in_vld  = 1'b1;
    in_tag  = TAG_W'(tag);
    in_data = data;
    in_resp = RESP_W'($urandom);
    in_last = last;
  endtask

  logic [APB-1:0] t1_words [4];
  logic [APB-1:0] held;

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    idle();
    preset = 1'b1;
    repeat (2) @(posedge pclk);
    #1;
    model_reset();
    check_outs();
    idle();

    // 1: two-beat burst on tag 1, four words lowest first
    t1_words[0] = 32'h3333_4444;
    t1_words[1] = 32'h1111_2222;
    t1_words[2] = 32'h7777_8888;
    t1_words[3] = 32'h5555_6666;
    push(1, 64'h1111_2222_3333_4444, 1'b0); tick();
    push(1, 64'h5555_6666_7777_8888, 1'b1); tick();
    idle();
    req_vld = 1'b1;
    req_tag = 2'd1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t1_word", 64'(out_data), 64'(t1_words[k]));
      chk("t1_last", 64'(out_last), 64'(k == 3));
    end
    idle(); tick();

    // 2: fill tag 0, overflow, drain with wrap, refill and drain again
    for (int k = 0; k < DEPTH; k++) begin
      push(0, {$urandom, $urandom}, 1'(k == DEPTH - 1)); tick();
    end
    push(0, {$urandom, $urandom}, 1'b1); tick();
    chk("t2_ovf0", 64'(ovf_err[0]), 64'd1);
    for (int pass = 0; pass < 2; pass++) begin
      idle();
      req_vld = 1'b1;
      req_tag = 2'd0;
      for (int k = 0; k < DEPTH * RATIO; k++) tick();
      idle();
      for (int k = 0; k < DEPTH && pass == 0; k++) begin
        push(0, {$urandom, $urandom}, 1'($urandom_range(0, 1))); tick();
      end
    end
    idle(); tick();

    // 3: empty response on tag 3, then flush clears its status
    req_vld = 1'b1;
    req_tag = 2'd3;
    tick();
    chk("t3_data", 64'(out_data), 64'd0);
    chk("t3_last", 64'(out_last), 64'd1);
    chk("t3_empty", 64'(out_empty), 64'd1);
    chk("t3_unf3", 64'(unf_err[3]), 64'd1);
    idle();
    flush_vld = 1'b1;
    flush_tag = 2'd3;
    tick();
    chk("t3_unf3_flushed", 64'(unf_err[3]), 64'd0);
    idle(); tick();

    // 4: backpressure holds the word stable
    push(2, {$urandom, $urandom}, 1'b1); tick();
    idle();
    req_vld = 1'b1;
    req_tag = 2'd2;
    out_rdy = 1'b0;
    tick();
    held = out_data;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_hold_data", 64'(out_data), 64'(held));
      chk("t4_hold_vld", 64'(out_vld), 64'd1);
    end
    req_vld = 1'b0;
    out_rdy = 1'b1;
    tick();
    chk("t4_released", 64'(out_vld), 64'd0);
    idle(); flush_vld = 1'b1; flush_tag = 2'd2; tick();
    idle();

    // 5: interleaved pushes on tags 0/2 with requests on tag 0 every cycle
    for (int k = 0; k < 12; k++) begin
      push((k % 2 == 1) ? 2 : 0, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      req_vld = 1'b1;
      req_tag = 2'd0;
      tick();
    end
    idle(); tick();
    for (int t = 0; t < TAG_NUM; t++) begin
      flush_vld = 1'b1; flush_tag = TAG_W'(t); tick();
    end
    idle();

    // 6: reset mid-slice, then the tag answers empty
    push(1, {$urandom, $urandom}, 1'b1); tick();
    idle();
    req_vld = 1'b1;
    req_tag = 2'd1;
    tick();
    idle();
    preset = 1'b1;
    tick();
    chk("t6_rst_vld", 64'(out_vld), 64'd0);
    chk("t6_rst_data", 64'(out_data), 64'd0);
    idle();
    req_vld = 1'b1;
    req_tag = 2'd1;
    tick();
    chk("t6_empty", 64'(out_empty), 64'd1);
    chk("t6_last", 64'(out_last), 64'd1);
    idle(); tick();

    // Randomised traffic
    for (int k = 0; k < 600; k++) begin
      idle();
      preset    = ($urandom_range(0, 99) == 0);
      in_vld    = ($urandom_range(0, 9) < 6);
      in_tag    = TAG_W'($urandom);
      in_data   = {$urandom, $urandom};
      in_resp   = RESP_W'($urandom);
      in_last   = 1'($urandom);
      req_vld   = ($urandom_range(0, 9) < 5);
      req_tag   = TAG_W'($urandom);
      out_rdy   = ($urandom_range(0, 9) < 7);
      flush_vld = ($urandom_range(0, 19) == 0);
      flush_tag = TAG_W'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/apb2axi_rsp_slicer.md
Name: apb2axi_rsp_slicer

Overview:
- Parametrised per-tag read-data buffer and APB word slicer for the APB2AXI bridge response path.
- Accepts AXI R beats tagged by transaction ID and stores them in per-tag circular queues.
- Serves APB-side drain requests one APB word at a time, lowest word first.
- Over the previous generation it adds: any AXI/APB width ratio, configurable depth, a per-tag flush, per-word response propagation, an explicit empty indication, and sticky overflow/underflow status.

Parameters:
TAG_NUM, 4, number of independent tag queues (≥1)
APB_DATA_W, 32, APB word width
AXI_DATA_W, 64, AXI beat width; must be APB_DATA_W×2^k, k≥0
BEATS_PER_TAG, 8, queue depth per tag; power of 2, ≥2
RESP_W, 2, AXI RRESP width

Ports:
pclk  in  1  clock; the only clock
preset  in  1  reset; synchronous, active-high
in_vld  in  1  R beat valid
in_rdy  out  1  R beat ready
in_tag  in  $clog2(TAG_NUM)  beat tag
in_data  in  AXI_DATA_W  beat data
in_resp  in  RESP_W  beat RRESP
in_last  in  1  beat is RLAST
req_vld  in  1  APB word request
req_rdy  out  1  request accepted
req_tag  in  $clog2(TAG_NUM)  tag to drain
out_vld  out  1  word valid
out_rdy  in  1  word consumed
out_data  out  APB_DATA_W  word
out_resp  out  RESP_W  RRESP of source beat
out_last  out  1  final word of final beat of burst
out_empty  out  1  request found no data
flush_vld  in  1  discard all state for flush_tag
flush_tag  in  $clog2(TAG_NUM)  tag to flush
tag_count  out  TAG_NUM×$clog2(BEATS_PER_TAG+1)  queued beats per tag, packed, tag 0 in LSBs
ovf_err  out  TAG_NUM  sticky: beat offered to a full tag queue
unf_err  out  TAG_NUM  sticky: empty response returned

Behaviour:
- Reset: preset=1 at a pclk edge clears all of the following to 0:
  - all queue pointers and counts;
  - slice state: cur_valid, cur_idx;
  - outputs out_vld, out_data, out_resp, out_last, out_empty;
  - status: ovf_err, unf_err.
  - Reset mid-burst drops all stored data. Storage array contents are not reset.
- Write side:
  - in_rdy = (count[in_tag] < BEATS_PER_TAG) && !(flush_vld && flush_tag==in_tag). Combinational.
  - On in_vld&&in_rdy, {data,resp,last} is written at tail[in_tag]; tail increments modulo BEATS_PER_TAG, count increments.
  - in_vld && !in_rdy due to full sets ovf_err[in_tag]; the beat is not stored.
- Request side:
  - req_rdy = (!out_vld || out_rdy) && !(flush_vld && flush_tag==req_tag).
  - On req_vld&&req_rdy, the output register loads on the next edge (latency 1). out_vld is held until out_rdy.
  - out_vld is deasserted on out_rdy unless a new request is accepted in the same cycle, which allows back-to-back words at full rate.
- Slicing, RATIO = AXI_DATA_W/APB_DATA_W, per tag:
  - cur_valid=0 and count>0: pop the head beat and emit word 0.
    - If RATIO>1, latch the beat into cur_data/resp/last, set cur_idx=1 and cur_valid=1.
  - cur_valid=1: emit word cur_idx and increment cur_idx. When cur_idx reaches RATIO, cur_valid=0.
  - out_last=1 only on word RATIO-1 of a beat whose last=1.
  - With RATIO=1 every pop emits directly and cur_* is unused.
- Empty: cur_valid=0 and count=0 at request → out_data=0, out_resp=0, out_last=1, out_empty=1; unf_err[tag] is set.
- Simultaneous push and pop on the same tag: count is unchanged; head and tail both advance.
  - A pop never observes a beat pushed in the same cycle; count=0 then yields the empty response.
- Flush: on flush_vld, for flush_tag:
  - head=tail=0, count=0, cur_valid=0;
  - ovf_err and unf_err bits for that tag are cleared.
  - Other tags are unaffected. An output word already registered remains valid.
- Pointer wrap: natural modulo BEATS_PER_TAG. count ranges over 0..BEATS_PER_TAG inclusive.

Test Plan:
1. RATIO=2, tag 1: push beats 0x1111_2222_3333_4444 (last=0) and 0x5555_6666_7777_8888 (last=1), then 4 requests → words 0x33334444, 0x11112222, 0x77778888, 0x55556666; out_last only on the 4th; tag_count[1] goes 2→1→1→0→0.
2. Fill tag 0 with 8 beats, push a 9th → in_rdy=0, ovf_err[0]=1; drain 16 words, data in order; pointers wrap correctly on a further 8 beats.
3. Request tag 3 with nothing stored → out_data=0, out_last=1, out_empty=1, unf_err[3]=1; flush tag 3 → unf_err[3]=0.
4. Hold out_rdy=0 for 5 cycles after a request → out_vld and out_data stable, req_rdy=0; release → word consumed once.
5. Interleave pushes to tags 0 and 2 with same-cycle requests on tag 0 → per-tag order preserved; same-cycle push/pop leaves count constant.
6. Assert preset mid-slice (cur_idx=1) → all outputs 0 next edge; a subsequent request returns the empty response.
